// File: rtl/fft_spectrum_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fft_spectrum_streamer                                        |
// | Description : Buffers one FFT frame as saturated |X|^2 words and streams   |
// |               it as A5 5A <count> + MSB-first bin bytes over valid/ready.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fft_spectrum_streamer #(
    parameter int IW    = 11,
    parameter int LOG2N = 8,
    parameter int HALF  = 1,
    parameter int SHIFT = 0,
    parameter int BYTES = 3
) (
    input  logic            sys_clock,
    input  logic            reset,
    input  logic            i_ce,
    input  logic            i_sync,
    input  logic [2*IW-1:0] i_data,
    output logic [7:0]      o_byte,
    output logic            o_valid,
    input  logic            i_ready,
    output logic            o_busy,
    output logic [7:0]      o_frame_cnt,
    output logic [7:0]      o_dropped
);

    localparam int SW  = 2 * IW;
    localparam int OW  = 8 * BYTES;
    localparam int AW  = (HALF != 0) ? LOG2N - 1 : LOG2N;
    localparam int NB  = 1 << AW;
    localparam int BCW = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [AW-1:0]  c_last_bin  = AW'(NB - 1);
    localparam logic [BCW-1:0] c_last_byte = BCW'(BYTES - 1);
    localparam logic [7:0]     c_sof0      = 8'hA5;
    localparam logic [7:0]     c_sof1      = 8'h5A;

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_capture = 2'd1;
    localparam logic [1:0] c_hdr     = 2'd2;
    localparam logic [1:0] c_data    = 2'd3;

    // ---------------- magnitude-squared pipeline ----------------
    logic signed [IW-1:0] w_re, w_im;
    logic signed [SW-1:0] w_re_ext, w_im_ext;
    logic signed [SW-1:0] r_s1_re_sq, r_s1_im_sq;
    logic                 r_s1_valid, r_s1_sync;
    logic [SW-1:0]        w_sum, w_shift;
    logic [OW-1:0]        w_sat;
    logic [OW-1:0]        r_s2_word;
    logic                 r_s2_valid, r_s2_sync;

    assign w_re     = i_data[SW-1:IW];
    assign w_im     = i_data[IW-1:0];
    assign w_re_ext = SW'(w_re);
    assign w_im_ext = SW'(w_im);
    // Both squares are non-negative and bounded by 2^(SW-2), so the sum fits unsigned.
    assign w_sum    = $unsigned(r_s1_re_sq) + $unsigned(r_s1_im_sq);
    assign w_shift  = w_sum >> SHIFT;

    generate
        if (OW >= SW) begin : g_no_sat
            assign w_sat = OW'(w_shift);
        end else begin : g_sat
            assign w_sat = (|w_shift[SW-1:OW]) ? {OW{1'b1}} : w_shift[OW-1:0];
        end
    endgenerate

    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sync  <= 1'b0;
            r_s1_re_sq <= '0;
            r_s1_im_sq <= '0;
            r_s2_valid <= 1'b0;
            r_s2_sync  <= 1'b0;
            r_s2_word  <= '0;
        end else begin
            r_s1_valid <= i_ce;
            r_s1_sync  <= i_ce & i_sync;
            if (i_ce) begin
                r_s1_re_sq <= w_re_ext * w_re_ext;
                r_s1_im_sq <= w_im_ext * w_im_ext;
            end
            r_s2_valid <= r_s1_valid;
            r_s2_sync  <= r_s1_sync;
            if (r_s1_valid) begin
                r_s2_word <= w_sat;
            end
        end
    end

    // ---------------- frame buffer and streaming FSM ----------------
    logic [1:0]     r_state;
    logic [AW-1:0]  r_widx, r_nidx, r_bin;
    logic [BCW-1:0] r_bcnt;
    logic [1:0]     r_hcnt;
    logic [OW-1:0]  r_word, r_rdata, w_word_sh;
    logic [7:0]     r_byte, r_frame_cnt, r_dropped;
    logic           r_valid;
    logic [OW-1:0]  r_mem [NB];

    logic          w_xfer, w_last_xfer, w_start, w_cap_write, w_we, w_load, w_drop;
    logic [AW-1:0] w_waddr, w_raddr, w_addr;

    assign w_xfer      = r_valid & i_ready;
    assign w_last_xfer = (r_state == c_data) && w_xfer && (r_bcnt == c_last_byte) &&
                         (r_bin == c_last_bin);
    // A frame arriving on the very cycle transmission ends is captured, not dropped.
    assign w_start     = r_s2_valid && r_s2_sync && ((r_state == c_idle) || w_last_xfer);
    assign w_cap_write = (r_state == c_capture) && r_s2_valid;
    assign w_we        = w_start || w_cap_write;
    assign w_drop      = r_s2_valid && r_s2_sync &&
                         ((r_state == c_hdr) || ((r_state == c_data) && !w_last_xfer));
    assign w_waddr     = (w_start || r_s2_sync) ? '0 : r_widx;

    // r_rdata always holds mem[r_nidx]; stepping the address on a load keeps the prefetch one bin ahead.
    assign w_load  = w_xfer && (((r_state == c_hdr) && (r_hcnt == 2'd2)) ||
                     ((r_state == c_data) && (r_bcnt == c_last_byte) && (r_bin != c_last_bin)));
    assign w_raddr = w_load ? r_nidx + AW'(1) : r_nidx;
    assign w_addr  = w_we ? w_waddr : w_raddr;

    assign w_word_sh = r_word << 8;

    always_ff @(posedge sys_clock) begin
        if (w_we) begin
            r_mem[w_addr] <= r_s2_word;
        end
        r_rdata <= r_mem[w_addr];
    end

    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            r_state     <= c_idle;
            r_widx      <= '0;
            r_nidx      <= '0;
            r_bin       <= '0;
            r_bcnt      <= '0;
            r_hcnt      <= '0;
            r_word      <= '0;
            r_byte      <= '0;
            r_valid     <= 1'b0;
            r_frame_cnt <= '0;
            r_dropped   <= '0;
        end else begin
            case (r_state)
                c_capture: begin
                    if (r_s2_valid) begin
                        if (r_s2_sync) begin
                            r_widx <= AW'(1);
                        end else begin
                            r_widx <= r_widx + AW'(1);
                            if (r_widx == c_last_bin) begin
                                r_state <= c_hdr;
                                r_nidx  <= '0;
                                r_bin   <= '0;
                                r_hcnt  <= '0;
                            end
                        end
                    end
                end
                c_hdr: begin
                    if (!r_valid) begin
                        r_byte  <= c_sof0;
                        r_valid <= 1'b1;
                    end else if (i_ready) begin
                        r_hcnt <= r_hcnt + 2'd1;
                        case (r_hcnt)
                            2'd0:    r_byte <= c_sof1;
                            2'd1:    r_byte <= r_frame_cnt;
                            default: begin
                                r_word  <= r_rdata;
                                r_byte  <= r_rdata[OW-1 -: 8];
                                r_nidx  <= r_nidx + AW'(1);
                                r_bcnt  <= '0;
                                r_state <= c_data;
                            end
                        endcase
                    end
                end
                c_data: begin
                    if (w_xfer) begin
                        if (r_bcnt != c_last_byte) begin
                            r_word <= w_word_sh;
                            r_byte <= w_word_sh[OW-1 -: 8];
                            r_bcnt <= r_bcnt + BCW'(1);
                        end else if (r_bin != c_last_bin) begin
                            r_word <= r_rdata;
                            r_byte <= r_rdata[OW-1 -: 8];
                            r_nidx <= r_nidx + AW'(1);
                            r_bin  <= r_bin + AW'(1);
                            r_bcnt <= '0;
                        end else begin
                            r_valid     <= 1'b0;
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                            r_state     <= c_idle;
                        end
                    end
                end
                default: ;
            endcase

            if (w_start) begin
                r_widx  <= AW'(1);
                r_state <= c_capture;
            end
            if (w_drop && (r_dropped != 8'hFF)) begin
                r_dropped <= r_dropped + 8'd1;
            end
        end
    end

    assign o_byte      = r_byte;
    assign o_valid     = r_valid;
    assign o_busy      = (r_state != c_idle);
    assign o_frame_cnt = r_frame_cnt;
    assign o_dropped   = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_fft_spectrum_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fft_spectrum_streamer                                     |
// | Description : Scoreboard bench: three streamer variants (BYTES/SHIFT).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fft_spectrum_streamer;

    logic        sys_clock = 1'b0;
    logic        reset     = 1'b0;
    logic        ce        = 1'b0;
    logic        sync      = 1'b0;
    logic [21:0] data      = '0;
    logic        ready     = 1'b1;
    logic        aux_en    = 1'b0;
    logic        ce_aux;

    logic [7:0] ob [3];
    logic       ov [3];
    logic       busy [3];
    logic [7:0] fcnt [3];
    logic [7:0] drop [3];

    int errors = 0;
    int checks = 0;
    int ecnt [3] = '{0, 0, 0};

    logic [7:0] q0[$], q1[$], q2[$];
    logic       stall_q [3] = '{0, 0, 0};
    logic [7:0] held [3];
    logic [7:0] m_exp;
    bit         m_have;

    always #5 sys_clock = ~sys_clock;
    assign ce_aux = ce & aux_en;

    fft_spectrum_streamer #(.IW(11), .LOG2N(3), .HALF(1), .SHIFT(0), .BYTES(3)) u_dut0 (
        .sys_clock(sys_clock), .reset(reset), .i_ce(ce), .i_sync(sync), .i_data(data),
        .o_byte(ob[0]), .o_valid(ov[0]), .i_ready(ready), .o_busy(busy[0]),
        .o_frame_cnt(fcnt[0]), .o_dropped(drop[0]));

    fft_spectrum_streamer #(.IW(11), .LOG2N(3), .HALF(1), .SHIFT(0), .BYTES(2)) u_dut1 (
        .sys_clock(sys_clock), .reset(reset), .i_ce(ce_aux), .i_sync(sync), .i_data(data),
        .o_byte(ob[1]), .o_valid(ov[1]), .i_ready(ready), .o_busy(busy[1]),
        .o_frame_cnt(fcnt[1]), .o_dropped(drop[1]));

    fft_spectrum_streamer #(.IW(11), .LOG2N(3), .HALF(1), .SHIFT(6), .BYTES(2)) u_dut2 (
        .sys_clock(sys_clock), .reset(reset), .i_ce(ce_aux), .i_sync(sync), .i_data(data),
        .o_byte(ob[2]), .o_valid(ov[2]), .i_ready(ready), .o_busy(busy[2]),
        .o_frame_cnt(fcnt[2]), .o_dropped(drop[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic void push_byte(input int d, input logic [7:0] b);
        case (d)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endfunction

    // Expected frame: header, then 4 identical bins MSB first.
    function automatic void push_frame(input int d, input logic [23:0] word);
        int nbytes;
        nbytes = (d == 0) ? 3 : 2;
        push_byte(d, 8'hA5);
        push_byte(d, 8'h5A);
        push_byte(d, 8'(ecnt[d]));
        ecnt[d]++;
        for (int k = 0; k < 4; k++)
            for (int b = nbytes - 1; b >= 0; b--)
                push_byte(d, word[8*b +: 8]);
    endfunction

    // Monitor: a transfer is committed at the next posedge when valid & ready here.
    always @(negedge sys_clock) begin
        if (!reset) begin
            for (int d = 0; d < 3; d++) stall_q[d] = 1'b0;
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (stall_q[d]) begin
                    chk($sformatf("stall_valid_dut%0d", d), 32'(ov[d]), 32'd1);
                    chk($sformatf("stall_byte_dut%0d", d), 32'(ob[d]), 32'(held[d]));
                end
                if (ov[d] && ready) begin
                    m_have = 1'b0;
                    case (d)
                        0: if (q0.size() > 0) begin m_exp = q0.pop_front(); m_have = 1'b1; end
                        1: if (q1.size() > 0) begin m_exp = q1.pop_front(); m_have = 1'b1; end
                        default: if (q2.size() > 0) begin m_exp = q2.pop_front(); m_have = 1'b1; end
                    endcase
                    if (!m_have) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte_dut%0d: got %02h required none", d, ob[d]);
                    end else begin
                        chk($sformatf("byte_dut%0d", d), 32'(ob[d]), 32'(m_exp));
                    end
                end
                stall_q[d] = ov[d] && !ready;
                held[d]    = ob[d];
            end
        end
    end

    task automatic tick();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic sample(input bit s, input int re, input int im);
        ce   = 1'b1;
        sync = s;
        data = {11'(re), 11'(im)};
        tick();
        ce   = 1'b0;
        sync = 1'b0;
    endtask

    task automatic frame(input int re, input int im);
        for (int i = 0; i < 8; i++) sample(i == 0, re, im);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((busy[0] || busy[1] || busy[2] || q0.size() > 0 || q1.size() > 0 ||
                q2.size() > 0) && n < 500) begin
            tick();
            n++;
        end
        chk({nm, "_idle_timeout"}, 32'(n < 500), 32'd1);
    endtask

    task automatic wait_q0(input int lvl, input string nm);
        int n;
        n = 0;
        while (q0.size() > lvl && n < 200) begin
            tick();
            n++;
        end
        chk({nm, "_progress_timeout"}, 32'(n < 200), 32'd1);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_valid", 32'(ov[0]), 32'd0);
        chk("rst_byte", 32'(ob[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_frame_cnt", 32'(fcnt[0]), 32'd0);
        chk("rst_dropped", 32'(drop[0]), 32'd0);
        reset = 1'b1;
        repeat (2) tick();

        // 1: basic frame, 3^2+4^2 = 25
        push_frame(0, 24'h000019);
        frame(3, 4);
        wait_idle("s1");
        chk("s1_frame_cnt", 32'(fcnt[0]), 32'd1);
        chk("s1_busy", 32'(busy[0]), 32'd0);

        // 2: (-1024)^2*2 = 2^21; saturation and shift variants
        aux_en = 1'b1;
        push_frame(0, 24'h200000);
        push_frame(1, 24'h00FFFF);
        push_frame(2, 24'h008000);
        frame(-1024, -1024);
        wait_idle("s2");
        aux_en = 1'b0;
        chk("s2_frame_cnt_b2", 32'(fcnt[1]), 32'd1);

        // 3: random backpressure
        push_frame(0, 24'h000019);
        frame(3, 4);
        for (int n = 0; n < 400 && busy[0]; n++) begin
            ready = 1'($urandom_range(0, 1));
            tick();
        end
        ready = 1'b1;
        wait_idle("s3");
        chk("s3_frame_cnt", 32'(fcnt[0]), 32'd3);

        // 4: overrun during DATA, then a clean frame; 5^2+12^2 = 169
        push_frame(0, 24'h0000A9);
        frame(5, 12);
        wait_q0(10, "s4");
        frame(1, 1);
        wait_idle("s4a");
        chk("s4_dropped", 32'(drop[0]), 32'd1);
        push_frame(0, 24'h000019);
        frame(3, 4);
        wait_idle("s4b");
        chk("s4_frame_cnt", 32'(fcnt[0]), 32'd5);
        chk("s4_dropped_hold", 32'(drop[0]), 32'd1);

        // 5: restart at bin 2; restarted bins are 2^2 = 4
        push_frame(0, 24'h000004);
        sample(1'b1, 7, 7);
        sample(1'b0, 7, 7);
        sample(1'b1, 2, 0);
        for (int i = 0; i < 7; i++) sample(1'b0, 2, 0);
        wait_idle("s5");

        // 6: reset mid-DATA
        push_frame(0, 24'h000019);
        frame(3, 4);
        wait_q0(8, "s6");
        chk("s6_pre_valid", 32'(ov[0]), 32'd1);
        reset = 1'b0;
        #1;
        chk("s6_rst_valid", 32'(ov[0]), 32'd0);
        chk("s6_rst_frame_cnt", 32'(fcnt[0]), 32'd0);
        chk("s6_rst_dropped", 32'(drop[0]), 32'd0);
        chk("s6_rst_busy", 32'(busy[0]), 32'd0);
        q0.delete();
        for (int d = 0; d < 3; d++) ecnt[d] = 0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        push_frame(0, 24'h000019);
        frame(3, 4);
        wait_idle("s6b");
        chk("s6_frame_cnt", 32'(fcnt[0]), 32'd1);

        chk("end_q0_empty", 32'(q0.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
